// File: rtl/bc_drr_queue.sv
// bc_drr_queue: decode-stage bus connect with a DEPTH-entry DRR FIFO.
// Optional macro BC_DRR_BYPASS_EN: same-cycle push->bus bypass on empty queue.
//
// Ports:
//   clk_dcd, rst            decode clock, sync active-high reset
//   ps_bc_drr_sclt/we/re    DRR source select, push, pop
//   ps_bc_di_sclt           bus source: dm / queue head / imm / zero
//   ps_bc_imm_sx            immediate sign-extend enable
//   ps_bc_err_clr           clears sticky ovf/udf
//   dm/dg/ps_bc_dt, xb_dtx  source data; ps_bc_immdt immediate
//   bc_dt                   registered bus data
//   bc_drr_cnt/full/empty   occupancy; bc_drr_ovf/udf sticky errors
module bc_drr_queue #(
  parameter int DW    = 16,
  parameter int IMMW  = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk_dcd,
  input  logic                       rst,
  input  logic [1:0]                 ps_bc_drr_sclt,
  input  logic                       ps_bc_drr_we,
  input  logic                       ps_bc_drr_re,
  input  logic [1:0]                 ps_bc_di_sclt,
  input  logic                       ps_bc_imm_sx,
  input  logic                       ps_bc_err_clr,
  input  logic [DW-1:0]              dm_bc_dt,
  input  logic [DW-1:0]              dg_bc_dt,
  input  logic [DW-1:0]              ps_bc_dt,
  input  logic [DW-1:0]              xb_dtx,
  input  logic [IMMW-1:0]            ps_bc_immdt,
  output logic [DW-1:0]              bc_dt,
  output logic [$clog2(DEPTH):0]     bc_drr_cnt,
  output logic                       bc_drr_full,
  output logic                       bc_drr_empty,
  output logic                       bc_drr_ovf,
  output logic                       bc_drr_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;

  logic [DW-1:0] drr_src;
  logic [DW-1:0] head;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] bus_nxt;
  logic          byp;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_set;
  logic          udf_set;

  assign bc_drr_cnt   = cnt;
  assign bc_drr_full  = (cnt == CW'(DEPTH));
  assign bc_drr_empty = (cnt == '0);

  always_comb begin
    drr_src = '0;
    case (ps_bc_drr_sclt)
      2'b00:   drr_src = dg_bc_dt;
      2'b01:   drr_src = ps_bc_dt;
      2'b10:   drr_src = xb_dtx;
      default: drr_src = '0;
    endcase
  end

`ifdef BC_DRR_BYPASS_EN
  assign byp = bc_drr_empty & ps_bc_drr_we & ps_bc_drr_re;
`else
  assign byp = 1'b0;
`endif

  // A pop frees the slot a full-queue push needs, so that pair is legal.
  assign push_ok = ps_bc_drr_we & (~bc_drr_full | ps_bc_drr_re) & ~byp;
  assign pop_ok  = ps_bc_drr_re & ~bc_drr_empty;
  assign ovf_set = ps_bc_drr_we & bc_drr_full & ~ps_bc_drr_re;
  assign udf_set = ps_bc_drr_re & bc_drr_empty & ~byp;

  assign head = bc_drr_empty ? '0 : mem[rptr];

  // Size-casting a signed value sign-extends; unsigned zero-extends.
  assign imm_ext = ps_bc_imm_sx ? DW'(signed'(ps_bc_immdt))
                                : DW'(ps_bc_immdt);

  always_comb begin
    bus_nxt = '0;
    case (ps_bc_di_sclt)
      2'b00:   bus_nxt = dm_bc_dt;
      2'b01:   bus_nxt = byp ? drr_src : head;
      2'b10:   bus_nxt = imm_ext;
      default: bus_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_dcd) begin
    if (push_ok) mem[wptr] <= drr_src;
  end

  always_ff @(posedge clk_dcd) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      bc_dt      <= '0;
      bc_drr_ovf <= 1'b0;
      bc_drr_udf <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      if (push_ok & ~pop_ok)      cnt <= cnt + CW'(1);
      else if (pop_ok & ~push_ok) cnt <= cnt - CW'(1);
      bc_dt      <= bus_nxt;
      bc_drr_ovf <= ovf_set | (bc_drr_ovf & ~ps_bc_err_clr);
      bc_drr_udf <= udf_set | (bc_drr_udf & ~ps_bc_err_clr);
    end
  end

endmodule

// File: tb/tb_bc_drr_queue.sv
// tb_bc_drr_queue: directed self-checking bench for bc_drr_queue.
// DUT built with DW=16, IMMW=8, DEPTH=4.
module tb_bc_drr_queue;

  logic        clk_dcd = 1'b0;
  logic        rst;
  logic [1:0]  ps_bc_drr_sclt;
  logic        ps_bc_drr_we;
  logic        ps_bc_drr_re;
  logic [1:0]  ps_bc_di_sclt;
  logic        ps_bc_imm_sx;
  logic        ps_bc_err_clr;
  logic [15:0] dm_bc_dt;
  logic [15:0] dg_bc_dt;
  logic [15:0] ps_bc_dt;
  logic [15:0] xb_dtx;
  logic [7:0]  ps_bc_immdt;
  logic [15:0] bc_dt;
  logic [2:0]  bc_drr_cnt;
  logic        bc_drr_full;
  logic        bc_drr_empty;
  logic        bc_drr_ovf;
  logic        bc_drr_udf;

  int checks = 0;
  int failures = 0;

  bc_drr_queue #(.DW(16), .IMMW(8), .DEPTH(4)) dut (
    .clk_dcd        (clk_dcd),
    .rst            (rst),
    .ps_bc_drr_sclt (ps_bc_drr_sclt),
    .ps_bc_drr_we   (ps_bc_drr_we),
    .ps_bc_drr_re   (ps_bc_drr_re),
    .ps_bc_di_sclt  (ps_bc_di_sclt),
    .ps_bc_imm_sx   (ps_bc_imm_sx),
    .ps_bc_err_clr  (ps_bc_err_clr),
    .dm_bc_dt       (dm_bc_dt),
    .dg_bc_dt       (dg_bc_dt),
    .ps_bc_dt       (ps_bc_dt),
    .xb_dtx         (xb_dtx),
    .ps_bc_immdt    (ps_bc_immdt),
    .bc_dt          (bc_dt),
    .bc_drr_cnt     (bc_drr_cnt),
    .bc_drr_full    (bc_drr_full),
    .bc_drr_empty   (bc_drr_empty),
    .bc_drr_ovf     (bc_drr_ovf),
    .bc_drr_udf     (bc_drr_udf)
  );

  always #5 clk_dcd = ~clk_dcd;

  task automatic step();
    @(posedge clk_dcd);
    #1;
  endtask

  task automatic idle();
    ps_bc_drr_we  = 1'b0;
    ps_bc_drr_re  = 1'b0;
    ps_bc_di_sclt = 2'b11;
    ps_bc_err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    ps_bc_drr_sclt = 2'($urandom);
    ps_bc_drr_we   = 1'($urandom);
    ps_bc_drr_re   = 1'($urandom);
    ps_bc_di_sclt  = 2'($urandom);
    ps_bc_imm_sx   = 1'($urandom);
    ps_bc_err_clr  = 1'($urandom);
    dm_bc_dt       = 16'($urandom);
    dg_bc_dt       = 16'($urandom);
    ps_bc_dt       = 16'($urandom);
    xb_dtx         = 16'($urandom);
    ps_bc_immdt    = 8'($urandom);
    step();
    step();
    checks++;
    if (bc_dt !== 16'h0) begin
      failures++;
      $display("FAIL reset_bc_dt got=%h exp=0000", bc_dt);
    end
    checks++;
    if (bc_drr_cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d exp=0", bc_drr_cnt);
    end
    checks++;
    if (bc_drr_empty !== 1'b1 || bc_drr_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=e%b f%b exp=e1 f0",
               bc_drr_empty, bc_drr_full);
    end
    checks++;
    if (bc_drr_ovf !== 1'b0 || bc_drr_udf !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=o%b u%b exp=o0 u0",
               bc_drr_ovf, bc_drr_udf);
    end
    rst = 1'b0;
    idle();
    step();
  endtask

  task automatic test_fill_drain();
    logic [15:0] v [4];
    v[0] = 16'h1111;
    v[1] = 16'h2222;
    v[2] = 16'h3333;
    v[3] = 16'h4444;
    ps_bc_drr_sclt = 2'b01;
    ps_bc_drr_we   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ps_bc_dt = v[i];
      step();
      checks++;
      if (bc_drr_cnt !== 3'(i + 1)) begin
        failures++;
        $display("FAIL fill_cnt[%0d] got=%0d exp=%0d",
                 i, bc_drr_cnt, i + 1);
      end
    end
    checks++;
    if (bc_drr_full !== 1'b1 || bc_drr_empty !== 1'b0) begin
      failures++;
      $display("FAIL fill_full got=f%b e%b exp=f1 e0",
               bc_drr_full, bc_drr_empty);
    end
    ps_bc_dt = 16'h5555;
    step();
    checks++;
    if (bc_drr_ovf !== 1'b1 || bc_drr_cnt !== 3'd4) begin
      failures++;
      $display("FAIL ovf_push got=o%b c%0d exp=o1 c4",
               bc_drr_ovf, bc_drr_cnt);
    end
    ps_bc_drr_we  = 1'b0;
    ps_bc_drr_re  = 1'b1;
    ps_bc_di_sclt = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bc_dt !== v[i]) begin
        failures++;
        $display("FAIL drain_dt[%0d] got=%h exp=%h", i, bc_dt, v[i]);
      end
    end
    checks++;
    if (bc_drr_empty !== 1'b1 || bc_drr_cnt !== 3'd0) begin
      failures++;
      $display("FAIL drain_empty got=e%b c%0d exp=e1 c0",
               bc_drr_empty, bc_drr_cnt);
    end
    checks++;
    if (bc_drr_udf !== 1'b0 || bc_drr_ovf !== 1'b1) begin
      failures++;
      $display("FAIL drain_err got=o%b u%b exp=o1 u0",
               bc_drr_ovf, bc_drr_udf);
    end
    idle();
    ps_bc_err_clr = 1'b1;
    step();
    checks++;
    if (bc_drr_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr got=%b exp=0", bc_drr_ovf);
    end
    idle();
  endtask

  task automatic test_wrap();
    ps_bc_drr_sclt = 2'b01;
    ps_bc_drr_we   = 1'b1;
    ps_bc_dt       = 16'h0100;
    step();
    ps_bc_drr_re  = 1'b1;
    ps_bc_di_sclt = 2'b01;
    for (int i = 0; i < 10; i++) begin
      ps_bc_dt = 16'(16'h0101 + i);
      step();
      checks++;
      if (bc_dt !== 16'(16'h0100 + i) || bc_drr_cnt !== 3'd1) begin
        failures++;
        $display("FAIL wrap[%0d] got=%h c%0d exp=%h c1",
                 i, bc_dt, bc_drr_cnt, 16'(16'h0100 + i));
      end
    end
    ps_bc_drr_we = 1'b0;
    step();
    checks++;
    if (bc_dt !== 16'h010A || bc_drr_empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_last got=%h e%b exp=010a e1",
               bc_dt, bc_drr_empty);
    end
    checks++;
    if (bc_drr_udf !== 1'b0 || bc_drr_ovf !== 1'b0) begin
      failures++;
      $display("FAIL wrap_err got=o%b u%b exp=o0 u0",
               bc_drr_ovf, bc_drr_udf);
    end
    idle();
  endtask

  task automatic test_full_push_pop();
    logic [15:0] e [4];
    e[0] = 16'hB002;
    e[1] = 16'hB003;
    e[2] = 16'hB004;
    e[3] = 16'hAAAA;
    ps_bc_drr_sclt = 2'b01;
    ps_bc_drr_we   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ps_bc_dt = 16'(16'hB001 + i);
      step();
    end
    ps_bc_drr_sclt = 2'b10;
    xb_dtx         = 16'hAAAA;
    ps_bc_drr_re   = 1'b1;
    ps_bc_di_sclt  = 2'b01;
    step();
    checks++;
    if (bc_dt !== 16'hB001 || bc_drr_cnt !== 3'd4) begin
      failures++;
      $display("FAIL full_pp got=%h c%0d exp=b001 c4",
               bc_dt, bc_drr_cnt);
    end
    checks++;
    if (bc_drr_ovf !== 1'b0 || bc_drr_full !== 1'b1) begin
      failures++;
      $display("FAIL full_pp_flags got=o%b f%b exp=o0 f1",
               bc_drr_ovf, bc_drr_full);
    end
    ps_bc_drr_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bc_dt !== e[i]) begin
        failures++;
        $display("FAIL full_pp_drain[%0d] got=%h exp=%h",
                 i, bc_dt, e[i]);
      end
    end
    checks++;
    if (bc_drr_empty !== 1'b1) begin
      failures++;
      $display("FAIL full_pp_empty got=%b exp=1", bc_drr_empty);
    end
    idle();
  endtask

  task automatic test_bus_mux();
    logic [1:0]  sel [5];
    logic        sx  [5];
    logic [7:0]  imm [5];
    logic [15:0] exp [5];
    sel[0] = 2'b10; sx[0] = 1'b1; imm[0] = 8'h80; exp[0] = 16'hFF80;
    sel[1] = 2'b10; sx[1] = 1'b0; imm[1] = 8'h80; exp[1] = 16'h0080;
    sel[2] = 2'b10; sx[2] = 1'b1; imm[2] = 8'h7F; exp[2] = 16'h007F;
    sel[3] = 2'b00; sx[3] = 1'b1; imm[3] = 8'hFF; exp[3] = 16'h5A5A;
    sel[4] = 2'b11; sx[4] = 1'b1; imm[4] = 8'hFF; exp[4] = 16'h0000;
    dm_bc_dt = 16'h5A5A;
    for (int i = 0; i < 5; i++) begin
      ps_bc_di_sclt = sel[i];
      ps_bc_imm_sx  = sx[i];
      ps_bc_immdt   = imm[i];
      step();
      checks++;
      if (bc_dt !== exp[i]) begin
        failures++;
        $display("FAIL bus_mux[%0d] got=%h exp=%h", i, bc_dt, exp[i]);
      end
    end
    ps_bc_di_sclt = 2'b01;
    step();
    checks++;
    if (bc_dt !== 16'h0000) begin
      failures++;
      $display("FAIL empty_head got=%h exp=0000", bc_dt);
    end
    idle();
  endtask

  task automatic test_bypass();
    ps_bc_drr_sclt = 2'b00;
    dg_bc_dt       = 16'h1234;
    ps_bc_drr_we   = 1'b1;
    ps_bc_drr_re   = 1'b1;
    ps_bc_di_sclt  = 2'b01;
    step();
`ifdef BC_DRR_BYPASS_EN
    checks++;
    if (bc_dt !== 16'h1234 || bc_drr_cnt !== 3'd0 ||
        bc_drr_udf !== 1'b0) begin
      failures++;
      $display("FAIL bypass got=%h c%0d u%b exp=1234 c0 u0",
               bc_dt, bc_drr_cnt, bc_drr_udf);
    end
    idle();
    ps_bc_drr_re = 1'b1;
    step();
`else
    checks++;
    if (bc_dt !== 16'h0000 || bc_drr_cnt !== 3'd1 ||
        bc_drr_udf !== 1'b1) begin
      failures++;
      $display("FAIL no_bypass got=%h c%0d u%b exp=0000 c1 u1",
               bc_dt, bc_drr_cnt, bc_drr_udf);
    end
`endif
    idle();
    ps_bc_err_clr = 1'b1;
    step();
    checks++;
    if (bc_drr_udf !== 1'b0) begin
      failures++;
      $display("FAIL udf_clr got=%b exp=0", bc_drr_udf);
    end
`ifndef BC_DRR_BYPASS_EN
    idle();
    ps_bc_drr_re  = 1'b1;
    ps_bc_di_sclt = 2'b01;
    step();
    checks++;
    if (bc_dt !== 16'h1234 || bc_drr_cnt !== 3'd0) begin
      failures++;
      $display("FAIL no_bypass_pop got=%h c%0d exp=1234 c0",
               bc_dt, bc_drr_cnt);
    end
`endif
    idle();
    ps_bc_drr_re  = 1'b1;
    ps_bc_err_clr = 1'b1;
    step();
    checks++;
    if (bc_drr_udf !== 1'b1 || bc_drr_cnt !== 3'd0) begin
      failures++;
      $display("FAIL udf_set_wins got=u%b c%0d exp=u1 c0",
               bc_drr_udf, bc_drr_cnt);
    end
    idle();
    ps_bc_err_clr = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset_override();
    ps_bc_drr_sclt = 2'b01;
    ps_bc_drr_we   = 1'b1;
    ps_bc_dt       = 16'h7777;
    step();
    rst           = 1'b1;
    ps_bc_di_sclt = 2'b00;
    dm_bc_dt      = 16'hFFFF;
    step();
    checks++;
    if (bc_drr_cnt !== 3'd0 || bc_dt !== 16'h0000 ||
        bc_drr_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_override got=%h c%0d e%b exp=0000 c0 e1",
               bc_dt, bc_drr_cnt, bc_drr_empty);
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_push_pop();
    test_bus_mux();
    test_bypass();
    test_reset_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bc_drr_queue.md
# bc_drr_queue

Parametrised bus-connect block for the decode stage. It selects one of four drive sources into a DEPTH-entry data-register-read (DRR) queue. Each cycle it also registers one of four inputs onto the internal data bus: data memory, DRR queue head, immediate, or zero. It replaces the single-entry previous-data register with a FIFO, and adds overflow/underflow flags, immediate sign extension, and optional same-cycle bypass.

## Interface
Parameters:
- DW, 16: data bus width.
- IMMW, 16: immediate width. Must satisfy 1 ≤ IMMW ≤ DW.
- DEPTH, 4: DRR queue entries. Must be a power of two, ≥ 2.

Ports:
- clk_dcd  in  1  decode clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- ps_bc_drr_sclt  in  2  DRR source: 00 dg_bc_dt, 01 ps_bc_dt, 10 xb_dtx, 11 zero.
- ps_bc_drr_we  in  1  push the selected DRR source into the queue.
- ps_bc_drr_re  in  1  pop the queue head.
- ps_bc_di_sclt  in  2  bus source: 00 dm_bc_dt, 01 queue head, 10 immediate, 11 zero.
- ps_bc_imm_sx  in  1  1 sign-extends the immediate to DW; 0 zero-extends it.
- ps_bc_err_clr  in  1  clears the sticky error flags.
- dm_bc_dt, dg_bc_dt, ps_bc_dt, xb_dtx  in  DW each  source data.
- ps_bc_immdt  in  IMMW  immediate.
- bc_dt  out  DW  registered bus data.
- bc_drr_cnt  out  $clog2(DEPTH)+1  queue occupancy.
- bc_drr_full, bc_drr_empty  out  1  occupancy flags, combinational from the count.
- bc_drr_ovf, bc_drr_udf  out  1  sticky overflow / underflow flags.

## Operation
- Queue storage:
  - Circular buffer with write and read pointers of $clog2(DEPTH) bits each; pointers wrap DEPTH-1 → 0.
  - bc_drr_cnt is tracked separately.
- Push (ps_bc_drr_we = 1, not full): mux(ps_bc_drr_sclt) is written at the write pointer; the write pointer increments.
- Pop (ps_bc_drr_re = 1, not empty): the read pointer increments.
- Simultaneous push and pop with the queue neither full nor empty: both occur; count is unchanged.
- Push while full:
  - Without a pop: data is dropped and bc_drr_ovf is set.
  - With a pop: both operations occur; count stays at DEPTH; no error.
- Pop while empty: no pointer change; bc_drr_udf is set. The bypass case in Configuration is the only exception.
- Sticky flags:
  - rst or ps_bc_err_clr clears them.
  - If clear and a set condition occur in the same cycle, set wins.
- Bus mux (sampled each cycle):
  - 00: dm_bc_dt.
  - 01: queue head as it was before that cycle's pop, or 0 when empty.
  - 10: immediate, extended to DW per ps_bc_imm_sx.
  - 11: 0.
  - The result is registered into bc_dt.
- Pops are independent of ps_bc_di_sclt. The controller pops when it consumes the head.
- Reset: pointers 0, cnt 0, bc_dt 0, ovf/udf 0, empty 1, full 0. Queue storage is not reset. Reset overrides every same-cycle request.

## Timing
- Push to visibility: data pushed at edge N is the head (when the queue was empty) and readable via di_sclt = 01 in cycle N. It appears on bc_dt after edge N+1.
- bc_dt latency: one cycle from select/data to output; there is no combinational input→bc_dt path.
- Status outputs: cnt, full and empty update at the same edge as the push/pop. ovf and udf assert at the edge following the offending request.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- BC_DRR_BYPASS_EN defined, with the queue empty and ps_bc_drr_we = ps_bc_drr_re = 1:
  - The pushed source value is registered directly into bc_dt when di_sclt = 01.
  - Nothing is stored; no udf is raised; cnt stays 0.
  - With di_sclt = 01 and the queue empty but no push, bc_dt gets 0.
- BC_DRR_BYPASS_EN undefined, same case:
  - The push is stored and the pop is counted as an underflow (udf set).
  - bc_dt gets 0 with di_sclt = 01; cnt becomes 1.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → bc_dt = 0, cnt = 0, empty = 1, ovf = udf = 0.
- Fill/drain with DEPTH = 4, drr_sclt = 01:
  - Push ps_bc_dt = 0x1111, 0x2222, 0x3333, 0x4444 → full = 1.
  - A 5th push of 0x5555 → ovf = 1, cnt = 4.
  - Pop ×4 with di_sclt = 01 → bc_dt = 0x1111 … 0x4444 in order, then empty = 1.
- Wrap-around: 10 interleaved push/pop pairs of incrementing values → output order preserved across the pointer wrap; cnt constant.
- Full with simultaneous push and pop: push xb_dtx = 0xAAAA and pop in the same cycle → no ovf, cnt = 4, 0xAAAA becomes the last entry.
- Immediate, IMMW = 8, immdt = 0x80:
  - sx = 1 → bc_dt = 0xFF80.
  - sx = 0 → bc_dt = 0x0080.
- Empty queue, push dg_bc_dt = 0x1234 and pop with di_sclt = 01:
  - With the macro: bc_dt = 0x1234, cnt = 0, udf = 0.
  - Without: bc_dt = 0, cnt = 1, udf = 1.
  - ps_bc_err_clr then clears udf.
